// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up init sequencer and periodic refresh-request timer.
// Optional refresh timer: define SDRAM_REFRESH_TIMER_EN to build it in.
// T_RP, T_RFC and T_MRD are expected to be at least 2 cycles.
module sdram_init_ctrl #(
    parameter int          CLK_FREQ_MHZ = 100,
    parameter int          T_POWERUP_US = 200,
    parameter int          T_RP         = 2,
    parameter int          T_RFC        = 7,
    parameter int          T_MRD        = 2,
    parameter int          INIT_REF_CNT = 8,
    parameter logic [12:0] MODE_REG     = 13'h0032,
    parameter int          REF_INTERVAL = 780
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        pll_locked,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic        init_done,
    output logic        ref_req,
    input  logic        ref_ack,
    output logic        ref_miss
);

    localparam int PWR_CYC = CLK_FREQ_MHZ * T_POWERUP_US;
    localparam int MAX_A   = (PWR_CYC > T_RFC) ? PWR_CYC : T_RFC;
    localparam int MAX_B   = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int MAXV    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAXV + 1);
    localparam int RW      = $clog2(INIT_REF_CNT + 1);

    localparam logic [3:0] CMD_INH = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_PWR,
        PRECHARGE,
        WAIT_RP,
        REFRESH,
        WAIT_RFC,
        LOAD_MODE,
        WAIT_MRD,
        DONE
    } state_t;

    state_t          state;
    logic            lock_s1;
    logic            lock_sync;
    logic [CW-1:0]   wcnt;
    logic [RW-1:0]   nref;
    logic [3:0]      cmd;
    logic [1:0]      ba_q;
    logic [12:0]     addr_q;
    logic            cke_q;
    logic            done_q;

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke  = cke_q;
    assign sdram_ba   = ba_q;
    assign sdram_addr = addr_q;
    assign init_done  = done_q;

    // Two-flop synchronizer for the asynchronous PLL lock status.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            lock_s1   <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_s1   <= pll_locked;
            lock_sync <= lock_s1;
        end
    end

    // Init sequencer; lock loss before DONE behaves like a reset.
    always_ff @(posedge clk_100m) begin
        if (rst || (!lock_sync && state != DONE)) begin
            state  <= IDLE;
            wcnt   <= '0;
            nref   <= '0;
            cke_q  <= 1'b0;
            cmd    <= CMD_INH;
            ba_q   <= '0;
            addr_q <= '0;
            done_q <= 1'b0;
        end else begin
            cmd    <= CMD_NOP;
            ba_q   <= '0;
            addr_q <= '0;
            unique case (state)
                IDLE: begin
                    cke_q <= 1'b1;
                    nref  <= '0;
                    wcnt  <= CW'(PWR_CYC - 1);
                    state <= WAIT_PWR;
                end
                WAIT_PWR: begin
                    if (wcnt == '0) begin
                        state  <= PRECHARGE;
                        cmd    <= CMD_PRE;
                        addr_q <= 13'h0400;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                PRECHARGE: begin
                    wcnt  <= CW'(T_RP - 2);
                    state <= WAIT_RP;
                end
                WAIT_RP: begin
                    if (wcnt == '0) begin
                        state <= REFRESH;
                        cmd   <= CMD_REF;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                REFRESH: begin
                    nref  <= nref + 1'b1;
                    wcnt  <= CW'(T_RFC - 2);
                    state <= WAIT_RFC;
                end
                WAIT_RFC: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else if (nref == RW'(INIT_REF_CNT)) begin
                        state  <= LOAD_MODE;
                        cmd    <= CMD_LMR;
                        addr_q <= MODE_REG;
                    end else begin
                        state <= REFRESH;
                        cmd   <= CMD_REF;
                    end
                end
                LOAD_MODE: begin
                    wcnt  <= CW'(T_MRD - 2);
                    state <= WAIT_MRD;
                end
                WAIT_MRD: begin
                    if (wcnt == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SDRAM_REFRESH_TIMER_EN
    localparam int RCW = $clog2(REF_INTERVAL + 1);

    logic [RCW-1:0] rcnt;
    logic           req_q;
    logic           miss_q;
    logic           wrap;

    assign wrap     = (rcnt == RCW'(REF_INTERVAL - 1));
    assign ref_req  = req_q;
    assign ref_miss = miss_q;

    // Free-running interval timer; a wrap wins over a same-cycle ack.
    always_ff @(posedge clk_100m) begin
        if (rst || state != DONE) begin
            rcnt   <= '0;
            req_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            miss_q <= 1'b0;
            if (wrap) begin
                rcnt   <= '0;
                req_q  <= 1'b1;
                miss_q <= req_q && !ref_ack;
            end else begin
                rcnt <= rcnt + 1'b1;
                if (ref_ack) begin
                    req_q <= 1'b0;
                end
            end
        end
    end
`else
    logic unused_ack;

    assign unused_ack = ref_ack;
    assign ref_req    = 1'b0;
    assign ref_miss   = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Directed bench for sdram_init_ctrl at default parameters.
// Works with or without SDRAM_REFRESH_TIMER_EN defined.
module tb_sdram_init_ctrl;

    logic        clk_100m;
    logic        rst;
    logic        pll_locked;
    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic        init_done;
    logic        ref_req;
    logic        ref_ack;
    logic        ref_miss;

    int checks = 0;
    int errors = 0;
    int c      = 0;

    sdram_init_ctrl dut (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .pll_locked (pll_locked),
        .sdram_cke  (sdram_cke),
        .sdram_cs_n (sdram_cs_n),
        .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n),
        .sdram_we_n (sdram_we_n),
        .sdram_ba   (sdram_ba),
        .sdram_addr (sdram_addr),
        .init_done  (init_done),
        .ref_req    (ref_req),
        .ref_ack    (ref_ack),
        .ref_miss   (ref_miss)
    );

    initial clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cmd_now();
        return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    endfunction

    function automatic logic at_reset_vals();
        return sdram_cke == 1'b0 && cmd_now() == 4'b1111 &&
               sdram_ba == 2'd0 && sdram_addr == 13'd0 &&
               init_done == 1'b0 && ref_req == 1'b0 &&
               ref_miss == 1'b0;
    endfunction

    task automatic reset_vals(input string tag);
        check({tag, "_cke"},  sdram_cke, 0);
        check({tag, "_cmd"},  cmd_now(), 4'b1111);
        check({tag, "_ba"},   sdram_ba, 0);
        check({tag, "_addr"}, sdram_addr, 0);
        check({tag, "_done"}, init_done, 0);
        check({tag, "_req"},  ref_req, 0);
        check({tag, "_miss"}, ref_miss, 0);
    endtask

    // Called right after the negedge where lock/reset was changed.
    task automatic wait_start();
        int n = 0;
        do begin
            @(negedge clk_100m);
            n++;
        end while (sdram_cke !== 1'b1 && n < 20);
        check("cke_lat", n, 3);
        c = 1;
    endtask

    function automatic int ref_index(int cc);
        for (int k = 0; k < 8; k++)
            if (cc == 20003 + 7 * k) return k;
        return -1;
    endfunction

    task automatic walk(input int last);
        int bad_nop  = 0;
        int bad_cke  = 0;
        int bad_done = 0;
        int nref     = 0;
        forever begin
            if (c == 20001) begin
                check("pre_cmd", cmd_now(), 4'b0010);
                check("pre_a10", sdram_addr[10], 1);
            end else if (ref_index(c) >= 0) begin
                check($sformatf("ref%0d_cmd", ref_index(c)),
                      cmd_now(), 4'b0001);
                nref++;
            end else if (c == 20059) begin
                check("lm_cmd",  cmd_now(), 4'b0000);
                check("lm_addr", sdram_addr, 13'h0032);
                check("lm_ba",   sdram_ba, 0);
            end else if (cmd_now() !== 4'b0111) begin
                bad_nop++;
            end
            if (sdram_cke !== 1'b1) bad_cke++;
            if (c == 20060 || c == 20061)
                check($sformatf("done_c%0d", c), init_done, c == 20061);
            else if (init_done !== (c >= 20061))
                bad_done++;
            if (c >= last) break;
            @(negedge clk_100m);
            c++;
        end
        check("nop_cycles", bad_nop, 0);
        check("cke_hold", bad_cke, 0);
        check("done_lvl", bad_done, 0);
        if (last >= 20052) check("ref_count", nref, 8);
    endtask

    function automatic logic exp_req(int cc);
`ifdef SDRAM_REFRESH_TIMER_EN
        return (cc >= 20841 && cc <= 20851) ||
               (cc >= 21621 && cc <= 21631) ||
               (cc >= 22401 && cc <= 24001);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_miss(int cc);
`ifdef SDRAM_REFRESH_TIMER_EN
        return cc == 23181 || cc == 23961;
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_refresh();
        int bad_req  = 0;
        int bad_miss = 0;
        int misses   = 0;
        int rise1    = 0;
        int rise2    = 0;
        logic prev   = 1'b0;
        while (c < 24002) begin
            @(negedge clk_100m);
            c++;
            ref_ack = 1'b0;
            if (ref_req !== exp_req(c)) bad_req++;
            if (ref_miss !== exp_miss(c)) bad_miss++;
            if (ref_miss === 1'b1) misses++;
            if (ref_req === 1'b1 && !prev) begin
                if (rise1 == 0) rise1 = c;
                else if (rise2 == 0) rise2 = c;
            end
            prev = ref_req;
            if (c inside {20840, 20841, 20851, 20852, 21620,
                          21621, 24001, 24002})
                check($sformatf("req_c%0d", c), ref_req, exp_req(c));
            if (c == 23181)
                check("miss_c23181", ref_miss, exp_miss(c));
            if (c inside {20851, 21631, 24001})
                ref_ack = 1'b1;
            if (init_done !== 1'b1 || cmd_now() !== 4'b0111)
                bad_req++;
        end
        ref_ack = 1'b0;
        check("req_sched", bad_req, 0);
        check("miss_sched", bad_miss, 0);
`ifdef SDRAM_REFRESH_TIMER_EN
        check("miss_count", misses, 2);
        check("req_period", rise2 - rise1, 780);
`else
        check("miss_count", misses, 0);
        check("req_never", rise1, 0);
`endif
    endtask

    initial begin
        int bad = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        ref_ack    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100m);
            if (i == 4) rst = 1'b0;
            if (!at_reset_vals()) bad++;
        end
        check("idle_hold", bad, 0);
        reset_vals("idle");

        pll_locked = 1'b1;
        wait_start();
        walk(100);
        rst = 1'b1;
        @(negedge clk_100m);
        reset_vals("midrst");
        rst = 1'b0;
        wait_start();

        walk(20030);
        pll_locked = 1'b0;
        @(negedge clk_100m);
        c++;
        check("drop_ref5", cmd_now(), 4'b0001);
        @(negedge clk_100m);
        c++;
        check("drop_cke_pre", sdram_cke, 1);
        @(negedge clk_100m);
        c++;
        reset_vals("drop");
        repeat (10) @(negedge clk_100m);
        check("drop_idle", at_reset_vals(), 1);

        pll_locked = 1'b1;
        wait_start();
        walk(20061);
        run_refresh();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
